// File: rtl/io_input_conditioner.sv
// -----------------------------------------------------------------------------
// io_input_conditioner
//
// Brings the board slide switches and push-buttons into the CPU clock domain.
// The buttons are debounced and sticky per-button press events are latched.
// Everything is packed into the 32-bit io0 CSR word read by the core.
//
// Parameters
//   DEBOUNCE_CYCLES : consecutive cycles a button must disagree with its
//                     stable state before the state flips (>= 1)
//
// Ports
//   clk         : CPU clock, all logic on the rising edge
//   rst         : asynchronous, active-high reset
//   SW[17:0]    : raw slide switches (asynchronous to clk)
//   KEY[3:0]    : raw push-buttons, active-low (asynchronous to clk)
//   event_clr   : per-button clear for key_event (and key_release)
//   sw_sync     : synchronized switches
//   key_pressed : debounced buttons, 1 = pressed
//   key_event   : sticky press-event flags
//   io0_data    : {rel, key_event, key_pressed, 2'b0, sw_sync}
//
// Optional feature macro: IO_RELEASE_EVENT_EN
//   Defined     : sticky release flags key_release[3:0] drive io0_data[31:28]
//   Not defined : io0_data[31:28] is tied to zero
// -----------------------------------------------------------------------------
module io_input_conditioner #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [17:0] SW,
   input  logic [3:0]  KEY,
   input  logic [3:0]  event_clr,
   output logic [17:0] sw_sync,
   output logic [3:0]  key_pressed,
   output logic [3:0]  key_event,
   output logic [31:0] io0_data
);

   localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [17:0]      sw_p0, sw_p1;
   logic [3:0]       key_p0, key_p1;
   logic [3:0]       raw;
   logic [3:0]       stable;
   logic [CNT_W-1:0] cnt [4];
   logic [3:0]       flip;
   logic [3:0]       rise;
   logic [3:0]       event_q;
   logic [3:0]       rel_bits;

   // ---- stage p0/p1: two-flop synchronizers ----
   // KEY flops reset to 1 (released) so leaving reset never looks like a press.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sw_p0  <= '0;
         sw_p1  <= '0;
         key_p0 <= 4'hF;
         key_p1 <= 4'hF;
      end else begin
         sw_p0  <= SW;
         sw_p1  <= sw_p0;
         key_p0 <= KEY;
         key_p1 <= key_p0;
      end
   end

   assign raw = ~key_p1;

   // A flip happens on the edge where the disagreement has lasted the full
   // window; any agreeing cycle in between restarts the count.
   always_comb begin
      flip = '0;
      for (int i = 0; i < 4; i++) begin
         flip[i] = (raw[i] != stable[i]) && (cnt[i] == CNT_LAST);
      end
   end

   assign rise = flip & raw;

   // ---- debounce state ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stable <= '0;
         for (int i = 0; i < 4; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (raw[i] == stable[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_LAST) begin
               stable[i] <= raw[i];
               cnt[i]    <= '0;
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
      end
   end

   // ---- sticky press events: set wins over clear ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         event_q <= '0;
      end else begin
         event_q <= rise | (event_q & ~event_clr);
      end
   end

`ifdef IO_RELEASE_EVENT_EN
   logic [3:0] fall;
   logic [3:0] key_release;

   assign fall = flip & ~raw;

   // ---- sticky release events: same clear bits, set wins ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         key_release <= '0;
      end else begin
         key_release <= fall | (key_release & ~event_clr);
      end
   end

   assign rel_bits = key_release;
`else
   assign rel_bits = 4'b0000;
`endif

   assign sw_sync     = sw_p1;
   assign key_pressed = stable;
   assign key_event   = event_q;
   assign io0_data    = {rel_bits, event_q, stable, 2'b00, sw_p1};

endmodule

// File: tb/tb_io_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_io_input_conditioner
//
// Scoreboard bench for io_input_conditioner with DEBOUNCE_CYCLES = 4.
// Each cycle the expected post-edge state is pushed when the inputs are
// driven, then popped and compared one time unit after the rising edge.
// Expected release flags follow IO_RELEASE_EVENT_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_io_input_conditioner;

   localparam int          DB  = 4;
   localparam logic [17:0] SWV = 18'h2A5A5;
`ifdef IO_RELEASE_EVENT_EN
   localparam bit REL_EN = 1'b1;
`else
   localparam bit REL_EN = 1'b0;
`endif

   typedef struct {
      logic [17:0] sw;
      logic [3:0]  kp;
      logic [3:0]  ev;
      logic [3:0]  rel;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [17:0] SW;
   logic [3:0]  KEY;
   logic [3:0]  event_clr;
   logic [17:0] sw_sync;
   logic [3:0]  key_pressed;
   logic [3:0]  key_event;
   logic [31:0] io0_data;

   exp_t        sb [$];
   exp_t        e;
   logic [31:0] exp_io;
   logic [17:0] e_sw;
   logic [3:0]  e_kp, e_ev, e_rel;
   int          checks;
   int          errors;

   io_input_conditioner #(.DEBOUNCE_CYCLES(DB)) dut (
      .clk         (clk),
      .rst         (rst),
      .SW          (SW),
      .KEY         (KEY),
      .event_clr   (event_clr),
      .sw_sync     (sw_sync),
      .key_pressed (key_pressed),
      .key_event   (key_event),
      .io0_data    (io0_data)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic test_reset();
      rst       = 1'b1;
      SW        = SWV;
      KEY       = 4'hF;
      event_clr = 4'h0;
      @(posedge clk); #1;
      checks++;
      if ({sw_sync, key_pressed, key_event, io0_data} !== 58'd0) begin
         errors++;
         $display("FAIL reset_hold got sw=%h kp=%h ev=%h io0=%h exp all 0",
                  sw_sync, key_pressed, key_event, io0_data);
      end
      @(posedge clk); #1;
      rst  = 1'b0;
      e_sw = '0; e_kp = '0; e_ev = '0; e_rel = '0;
      for (int n = 1; n <= 3; n++) begin
         e_sw = (n >= 2) ? SWV : 18'd0;
         sb.push_back('{e_sw, e_kp, e_ev, e_rel});
         @(posedge clk); #1;
         e = sb.pop_front();
         exp_io = {e.rel, e.ev, e.kp, 2'b00, e.sw};
         checks++;
         if ({sw_sync, key_pressed, key_event, io0_data} !== {e.sw, e.kp, e.ev, exp_io}) begin
            errors++;
            $display("FAIL reset_sw n=%0d got sw=%h kp=%h ev=%h io0=%h exp sw=%h kp=%h ev=%h io0=%h",
                     n, sw_sync, key_pressed, key_event, io0_data, e.sw, e.kp, e.ev, exp_io);
         end
      end
   endtask

   task automatic test_press();
      for (int n = 1; n <= 8; n++) begin
         if (n == 1) KEY[0] = 1'b0;
         if (n >= 2 + DB) begin
            e_kp[0] = 1'b1;
            e_ev[0] = 1'b1;
         end
         sb.push_back('{e_sw, e_kp, e_ev, e_rel});
         @(posedge clk); #1;
         e = sb.pop_front();
         exp_io = {e.rel, e.ev, e.kp, 2'b00, e.sw};
         checks++;
         if ({sw_sync, key_pressed, key_event, io0_data} !== {e.sw, e.kp, e.ev, exp_io}) begin
            errors++;
            $display("FAIL press n=%0d got kp=%h ev=%h io0=%h exp kp=%h ev=%h io0=%h",
                     n, key_pressed, key_event, io0_data, e.kp, e.ev, exp_io);
         end
      end
   endtask

   task automatic test_release();
      for (int n = 1; n <= 8; n++) begin
         if (n == 1) KEY[0] = 1'b1;
         if (n >= 2 + DB) begin
            e_kp[0] = 1'b0;
            if (REL_EN) e_rel[0] = 1'b1;
         end
         sb.push_back('{e_sw, e_kp, e_ev, e_rel});
         @(posedge clk); #1;
         e = sb.pop_front();
         exp_io = {e.rel, e.ev, e.kp, 2'b00, e.sw};
         checks++;
         if ({sw_sync, key_pressed, key_event, io0_data} !== {e.sw, e.kp, e.ev, exp_io}) begin
            errors++;
            $display("FAIL release n=%0d got kp=%h ev=%h io0=%h exp kp=%h ev=%h io0=%h",
                     n, key_pressed, key_event, io0_data, e.kp, e.ev, exp_io);
         end
      end
      // clear both flags of button 0 with a one-cycle pulse
      for (int n = 1; n <= 2; n++) begin
         event_clr = (n == 1) ? 4'b0001 : 4'b0000;
         if (n == 1) begin
            e_ev[0]  = 1'b0;
            e_rel[0] = 1'b0;
         end
         sb.push_back('{e_sw, e_kp, e_ev, e_rel});
         @(posedge clk); #1;
         e = sb.pop_front();
         exp_io = {e.rel, e.ev, e.kp, 2'b00, e.sw};
         checks++;
         if ({sw_sync, key_pressed, key_event, io0_data} !== {e.sw, e.kp, e.ev, exp_io}) begin
            errors++;
            $display("FAIL clear0 n=%0d got kp=%h ev=%h io0=%h exp kp=%h ev=%h io0=%h",
                     n, key_pressed, key_event, io0_data, e.kp, e.ev, exp_io);
         end
      end
   endtask

   task automatic test_glitch();
      for (int n = 1; n <= 12; n++) begin
         KEY[1] = (n <= DB - 1) ? 1'b0 : 1'b1;
         sb.push_back('{e_sw, e_kp, e_ev, e_rel});
         @(posedge clk); #1;
         e = sb.pop_front();
         exp_io = {e.rel, e.ev, e.kp, 2'b00, e.sw};
         checks++;
         if ({sw_sync, key_pressed, key_event, io0_data} !== {e.sw, e.kp, e.ev, exp_io}) begin
            errors++;
            $display("FAIL glitch n=%0d got kp=%h ev=%h io0=%h exp kp=%h ev=%h io0=%h",
                     n, key_pressed, key_event, io0_data, e.kp, e.ev, exp_io);
         end
      end
   endtask

   task automatic test_event_clr();
      // phase 0: press, 1: clear pulse, 2: release, 3: press with clear on set edge, 4: release
      for (int ph = 0; ph < 5; ph++) begin
         for (int n = 1; n <= ((ph == 1) ? 2 : 8); n++) begin
            event_clr = 4'b0000;
            case (ph)
               0: begin
                  if (n == 1) KEY[2] = 1'b0;
                  if (n >= 2 + DB) begin e_kp[2] = 1'b1; e_ev[2] = 1'b1; end
               end
               1: begin
                  if (n == 1) begin event_clr = 4'b0100; e_ev[2] = 1'b0; end
               end
               2, 4: begin
                  if (n == 1) KEY[2] = 1'b1;
                  if (n >= 2 + DB) begin
                     e_kp[2] = 1'b0;
                     if (REL_EN) e_rel[2] = 1'b1;
                  end
               end
               default: begin
                  if (n == 1) KEY[2] = 1'b0;
                  if (n == 2 + DB) begin
                     event_clr = 4'b0100;
                     e_kp[2]   = 1'b1;
                     e_ev[2]   = 1'b1;
                     e_rel[2]  = 1'b0;
                  end
               end
            endcase
            sb.push_back('{e_sw, e_kp, e_ev, e_rel});
            @(posedge clk); #1;
            e = sb.pop_front();
            exp_io = {e.rel, e.ev, e.kp, 2'b00, e.sw};
            checks++;
            if ({sw_sync, key_pressed, key_event, io0_data} !== {e.sw, e.kp, e.ev, exp_io}) begin
               errors++;
               $display("FAIL event_clr ph=%0d n=%0d got kp=%h ev=%h io0=%h exp kp=%h ev=%h io0=%h",
                        ph, n, key_pressed, key_event, io0_data, e.kp, e.ev, exp_io);
            end
         end
      end
      event_clr = 4'b0000;
   endtask

   task automatic test_simultaneous();
      for (int ph = 0; ph < 2; ph++) begin
         for (int n = 1; n <= 7; n++) begin
            if (n == 1) KEY[1:0] = (ph == 0) ? 2'b00 : 2'b11;
            if (n >= 2 + DB) begin
               if (ph == 0) begin
                  e_kp[1:0] = 2'b11;
                  e_ev[1:0] = 2'b11;
               end else begin
                  e_kp[1:0] = 2'b00;
                  if (REL_EN) e_rel[1:0] = 2'b11;
               end
            end
            sb.push_back('{e_sw, e_kp, e_ev, e_rel});
            @(posedge clk); #1;
            e = sb.pop_front();
            exp_io = {e.rel, e.ev, e.kp, 2'b00, e.sw};
            checks++;
            if ({sw_sync, key_pressed, key_event, io0_data} !== {e.sw, e.kp, e.ev, exp_io}) begin
               errors++;
               $display("FAIL simul ph=%0d n=%0d got kp=%h ev=%h io0=%h exp kp=%h ev=%h io0=%h",
                        ph, n, key_pressed, key_event, io0_data, e.kp, e.ev, exp_io);
            end
         end
      end
   endtask

   task automatic test_rst_mid();
      // press KEY[3] and stop after edge 4, where its count has reached 2
      for (int n = 1; n <= 4; n++) begin
         if (n == 1) KEY[3] = 1'b0;
         sb.push_back('{e_sw, e_kp, e_ev, e_rel});
         @(posedge clk); #1;
         e = sb.pop_front();
         exp_io = {e.rel, e.ev, e.kp, 2'b00, e.sw};
         checks++;
         if ({sw_sync, key_pressed, key_event, io0_data} !== {e.sw, e.kp, e.ev, exp_io}) begin
            errors++;
            $display("FAIL rst_pre n=%0d got kp=%h ev=%h io0=%h exp kp=%h ev=%h io0=%h",
                     n, key_pressed, key_event, io0_data, e.kp, e.ev, exp_io);
         end
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({sw_sync, key_pressed, key_event, io0_data} !== 58'd0) begin
         errors++;
         $display("FAIL rst_async got sw=%h kp=%h ev=%h io0=%h exp all 0",
                  sw_sync, key_pressed, key_event, io0_data);
      end
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst  = 1'b0;
      e_sw = '0; e_kp = '0; e_ev = '0; e_rel = '0;
      for (int n = 1; n <= 7; n++) begin
         e_sw = (n >= 2) ? SWV : 18'd0;
         if (n >= 2 + DB) begin
            e_kp[3] = 1'b1;
            e_ev[3] = 1'b1;
         end
         sb.push_back('{e_sw, e_kp, e_ev, e_rel});
         @(posedge clk); #1;
         e = sb.pop_front();
         exp_io = {e.rel, e.ev, e.kp, 2'b00, e.sw};
         checks++;
         if ({sw_sync, key_pressed, key_event, io0_data} !== {e.sw, e.kp, e.ev, exp_io}) begin
            errors++;
            $display("FAIL rst_post n=%0d got sw=%h kp=%h ev=%h io0=%h exp sw=%h kp=%h ev=%h io0=%h",
                     n, sw_sync, key_pressed, key_event, io0_data, e.sw, e.kp, e.ev, exp_io);
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_press();
      test_release();
      test_glitch();
      test_event_clr();
      test_simultaneous();
      test_rst_mid();
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_leftover got %0d entries exp 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
